arbiter_puf_engine: RTL and testbench
=====================================

Name: arbiter_puf_engine

Overview:
- Sequential, parametrised arbiter-PUF evaluator. It is the next generation of the combinational `arbiter_puf` model.
- Evaluates M independent delay chains of N stages each, against one challenge, using the additive delay-difference model.
- One stage per clock. Optional LFSR noise injection, plus majority voting over VOTES repeated evaluations.
- Valid/ready handshakes on the challenge and response sides, so it drops into the same PUF test infrastructure.

Parameters:
- N, 4, number of challenge bits / stages per chain (>=1).
- M, 1, number of response bits = number of chains (>=1).
- DW, 4, width of each signed stage delay value.
- DELAY, 32'h11111111, packed signed delays. Width M*N*2*DW. Value for chain k, stage i, select s is at DELAY[((k*N+i)*2+s)*DW +: DW]. s=0 is p (challenge bit 0); s=1 is q (challenge bit 1).
- VOTES, 1, evaluations per challenge. Must be odd; an even value resolves ties to 0.
- NOISE_BITS, 0, width of the signed noise added at the arbiter (0 = noiseless, max 8).
- LFSR_SEED, 16'hACE1, LFSR reset value. A value of 0 is replaced by 16'hACE1.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- chal_valid  input  1  challenge offered
- chal_ready  output  1  engine idle, can accept
- challenge  input  N  challenge bits; bit i drives stage i
- resp_valid  output  1  response available
- resp_ready  input  1  consumer takes response
- response  output  M  majority-voted response; bit k from chain k
- busy  output  1  evaluation in progress (state STAGE or ARB)

Behaviour:
- Reset (rst=0, async), all held while low:
  - state=IDLE; chal_ready=1; resp_valid=0; response=0; busy=0.
  - Deltas, vote counters, stage/vote indices = 0; LFSR=seed.
- Internal widths:
  - Accumulator width AW = DW + clog2(N+1) + 2, signed; stage delays sign-extended to AW.
  - No overflow possible for legal parameters.
- States: IDLE, STAGE, ARB, DONE.
- IDLE:
  - chal_ready=1.
  - On chal_valid && chal_ready: latch challenge, clear deltas/vote counters/indices, go STAGE.
- STAGE (stage index i):
  - Per chain k: if c[i]=0, delta = delta + p(k,i); if c[i]=1, delta = -delta + q(k,i).
  - After i=N-1 go ARB, else i++.
- ARB:
  - Per chain k: bit_k = (delta_k + noise_k) > 0. A tie or negative gives 0.
  - noise_k = sign-extended low NOISE_BITS of the LFSR rotated left by k; 0 when NOISE_BITS=0.
  - vote_k += bit_k. LFSR steps once per ARB cycle (x^16+x^14+x^13+x^11+1, Fibonacci).
  - If vote index = VOTES-1: response_k = (final vote_k*2 > VOTES), register it, go DONE.
  - Otherwise clear deltas, i=0, vote index++, go STAGE.
- DONE:
  - resp_valid=1; response held stable.
  - On resp_ready: go IDLE, resp_valid=0 next cycle.
  - resp_ready low stalls indefinitely.
- Latency:
  - resp_valid rises VOTES*(N+1) clock edges after the accepting edge. N=4, VOTES=1 gives 5.
  - Throughput: one challenge per VOTES*(N+1)+2 cycles minimum; no overlap of challenges.
- Boundary rules:
  - chal_valid while not IDLE is ignored (no ready). challenge changes after accept have no effect.
  - resp_ready while not DONE is ignored.
  - Reset mid-evaluation aborts with no partial response. The LFSR returns to seed.
  - N=1 and M=1 are legal.

Test Plan:
- Reset/idle: rst=0 then release, N=4, M=1, defaults -> chal_ready=1, resp_valid=0, response=0, busy=0.
- Default delays (all p=q=+1), challenge 4'b0000 -> delta 1,2,3,4; response=1; resp_valid exactly 5 edges after accept.
- challenge 4'b1111 -> delta 1,0,1,0 (tie) -> response=0. challenge 4'b0001 -> response=1. challenge 4'b1000 -> delta ends -2 -> response=0.
- VOTES=3, NOISE_BITS=2, challenge 4'b0000 -> delta+noise >= 2 every vote; response=1; resp_valid after 15 edges; busy high throughout.
- Backpressure: hold resp_ready=0 for 20 cycles in DONE -> resp_valid and response stable, chal_ready=0, a new chal_valid is ignored; resp_ready=1 -> IDLE next cycle.
- M=2, chain 1 p=q=-1, challenge 4'b0000 -> response=2'b01. Assert rst mid-STAGE -> outputs at reset values immediately; next challenge is evaluated correctly.

Source files
------------

// File: rtl/arbiter_puf_engine.sv
// Sequential arbiter-PUF evaluator: M delay chains of N stages, one stage per
// clock, optional LFSR noise at the arbiter, majority vote over VOTES runs.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a challenge
// STAGE | accumulating one stage of every chain per clock
// ARB   | arbiter decision for every chain, vote tally, LFSR step
// DONE  | response held until the consumer takes it
module arbiter_puf_engine #(
    parameter int          N          = 4,
    parameter int          M          = 1,
    parameter int          DW         = 4,
    parameter logic [M*N*2*DW-1:0] DELAY = 32'h11111111,
    parameter int          VOTES      = 1,
    parameter int          NOISE_BITS = 0,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         chal_valid,
    output logic         chal_ready,
    input  logic [N-1:0] challenge,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [M-1:0] response,
    output logic         busy
);

    // Accumulator width leaves headroom for N stage additions plus a negation.
    localparam int AW = DW + $clog2(N + 1) + 2;
    // Arbiter sum is wide enough for the accumulator and the largest noise term.
    localparam int SW = ((AW > NOISE_BITS) ? AW : NOISE_BITS) + 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int VW = (VOTES > 1) ? $clog2(VOTES) : 1;
    localparam int CW = $clog2(VOTES + 1);
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STAGE = 2'd1,
        ARB   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state_q, state_nxt;
    logic [N-1:0]          chal_q, chal_nxt;
    logic signed [AW-1:0]  delta_q [M];
    logic signed [AW-1:0]  delta_nxt [M];
    logic [CW-1:0]         vote_q [M];
    logic [CW-1:0]         vote_nxt [M];
    logic [IW-1:0]         stage_q, stage_nxt;
    logic [VW-1:0]         vidx_q, vidx_nxt;
    logic [15:0]           lfsr_q, lfsr_nxt;
    logic [M-1:0]          resp_q, resp_nxt;

    logic signed [SW-1:0]  arb_sum;
    logic                  arb_bit;
    logic [CW-1:0]         vote_tot;

    // Signed delay of chain k, stage i, select s, sign-extended to AW.
    function automatic logic signed [AW-1:0] stage_delay(input int k, input int i, input int s);
        logic signed [DW-1:0] d;
        d = DELAY[((k * N + i) * 2 + s) * DW +: DW];
        return {{(AW - DW){d[DW-1]}}, d};
    endfunction

    // Noise for chain k: low NOISE_BITS of the LFSR rotated left by k, sign-extended.
    function automatic logic signed [SW-1:0] noise_of(input logic [15:0] lf, input int k);
        logic [15:0]          r;
        logic signed [SW-1:0] n;
        int                   sh;
        int                   msb;
        sh  = k % 16;
        r   = (lf << sh) | (lf >> ((16 - sh) % 16));
        msb = (NOISE_BITS > 0) ? NOISE_BITS - 1 : 0;
        n   = '0;
        if (NOISE_BITS > 0) begin
            for (int b = 0; b < SW; b++) begin
                n[b] = (b < NOISE_BITS) ? r[b[3:0]] : r[msb[3:0]];
            end
        end
        return n;
    endfunction

    // Fibonacci LFSR, taps x^16 + x^14 + x^13 + x^11 + 1.
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Datapath registers: challenge latch, accumulators, tallies, indices, LFSR, response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chal_q  <= '0;
            stage_q <= '0;
            vidx_q  <= '0;
            lfsr_q  <= SEED;
            resp_q  <= '0;
            for (int k = 0; k < M; k++) begin
                delta_q[k] <= '0;
                vote_q[k]  <= '0;
            end
        end else begin
            chal_q  <= chal_nxt;
            stage_q <= stage_nxt;
            vidx_q  <= vidx_nxt;
            lfsr_q  <= lfsr_nxt;
            resp_q  <= resp_nxt;
            for (int k = 0; k < M; k++) begin
                delta_q[k] <= delta_nxt[k];
                vote_q[k]  <= vote_nxt[k];
            end
        end
    end

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_nxt = state_q;
        chal_nxt  = chal_q;
        stage_nxt = stage_q;
        vidx_nxt  = vidx_q;
        lfsr_nxt  = lfsr_q;
        resp_nxt  = resp_q;
        arb_sum   = '0;
        arb_bit   = 1'b0;
        vote_tot  = '0;
        for (int k = 0; k < M; k++) begin
            delta_nxt[k] = delta_q[k];
            vote_nxt[k]  = vote_q[k];
        end

        chal_ready = (state_q == IDLE);
        resp_valid = (state_q == DONE);
        busy       = (state_q == STAGE) || (state_q == ARB);
        response   = resp_q;

        case (state_q)
            IDLE: begin
                if (chal_valid) begin
                    chal_nxt  = challenge;
                    stage_nxt = '0;
                    vidx_nxt  = '0;
                    for (int k = 0; k < M; k++) begin
                        delta_nxt[k] = '0;
                        vote_nxt[k]  = '0;
                    end
                    state_nxt = STAGE;
                end
            end

            STAGE: begin
                for (int k = 0; k < M; k++) begin
                    if (chal_q[stage_q]) begin
                        delta_nxt[k] = -delta_q[k] + stage_delay(k, int'(stage_q), 1);
                    end else begin
                        delta_nxt[k] = delta_q[k] + stage_delay(k, int'(stage_q), 0);
                    end
                end
                if (stage_q == IW'(N - 1)) begin
                    state_nxt = ARB;
                end else begin
                    stage_nxt = stage_q + 1'b1;
                end
            end

            ARB: begin
                lfsr_nxt = lfsr_step(lfsr_q);
                for (int k = 0; k < M; k++) begin
                    arb_sum     = {{(SW - AW){delta_q[k][AW-1]}}, delta_q[k]} + noise_of(lfsr_q, k);
                    // Strictly positive wins; a tie resolves to 0.
                    arb_bit     = !arb_sum[SW-1] && (arb_sum != '0);
                    vote_tot    = vote_q[k] + CW'(arb_bit);
                    vote_nxt[k] = vote_tot;
                    if (vidx_q == VW'(VOTES - 1)) begin
                        resp_nxt[k] = (int'(vote_tot) * 2 > VOTES);
                    end
                end
                if (vidx_q == VW'(VOTES - 1)) begin
                    state_nxt = DONE;
                end else begin
                    for (int k = 0; k < M; k++) begin
                        delta_nxt[k] = '0;
                    end
                    stage_nxt = '0;
                    vidx_nxt  = vidx_q + 1'b1;
                    state_nxt = STAGE;
                end
            end

            DONE: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_arbiter_puf_engine.sv
// Directed bench: three engine configurations (default, voting with noise,
// two chains) driven from a vector table plus hand-written corner sequences.
module tb_arbiter_puf_engine;

    logic clk;
    logic rst;

    logic       cv   [3];
    logic [3:0] ch   [3];
    logic       rr   [3];
    logic       crdy [3];
    logic       rv   [3];
    logic       bsy  [3];
    logic [1:0] rsp  [3];

    logic       rsp_a;
    logic       rsp_b;
    logic [1:0] rsp_c;

    int n_checks;
    int n_fail;

    assign rsp[0] = {1'b0, rsp_a};
    assign rsp[1] = {1'b0, rsp_b};
    assign rsp[2] = rsp_c;

    // Default configuration: N=4, M=1, all delays +1, single vote, noiseless.
    arbiter_puf_engine u_a (
        .clk        (clk),
        .rst        (rst),
        .chal_valid (cv[0]),
        .chal_ready (crdy[0]),
        .challenge  (ch[0]),
        .resp_valid (rv[0]),
        .resp_ready (rr[0]),
        .response   (rsp_a),
        .busy       (bsy[0])
    );

    // Three votes with 2-bit noise.
    arbiter_puf_engine #(.VOTES(3), .NOISE_BITS(2)) u_b (
        .clk        (clk),
        .rst        (rst),
        .chal_valid (cv[1]),
        .chal_ready (crdy[1]),
        .challenge  (ch[1]),
        .resp_valid (rv[1]),
        .resp_ready (rr[1]),
        .response   (rsp_b),
        .busy       (bsy[1])
    );

    // Two chains: chain 0 all +1, chain 1 all -1.
    arbiter_puf_engine #(.M(2), .DELAY(64'hFFFFFFFF_11111111)) u_c (
        .clk        (clk),
        .rst        (rst),
        .chal_valid (cv[2]),
        .chal_ready (crdy[2]),
        .challenge  (ch[2]),
        .resp_valid (rv[2]),
        .resp_ready (rr[2]),
        .response   (rsp_c),
        .busy       (bsy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         sel;
        logic [3:0] chal;
        logic [1:0] exp;
        int         lat;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Offer one challenge, measure latency, check response, then consume it.
    task automatic run(input int s, input logic [3:0] c, input logic [1:0] exp, input int lat);
        int edges;
        int busy_lo;
        @(posedge clk); #1;
        check($sformatf("ready_before[%0d,%b]", s, c), 32'(crdy[s]), 32'd1);
        cv[s] = 1'b1;
        ch[s] = c;
        @(posedge clk); #1;
        cv[s] = 1'b0;
        ch[s] = ~c;
        edges   = 0;
        busy_lo = 0;
        while (!rv[s] && edges < 200) begin
            if (!bsy[s]) busy_lo++;
            @(posedge clk); #1;
            edges++;
        end
        check($sformatf("latency[%0d,%b]", s, c), 32'(edges), 32'(lat));
        check($sformatf("busy_low_cycles[%0d,%b]", s, c), 32'(busy_lo), 32'd0);
        check($sformatf("response[%0d,%b]", s, c), 32'(rsp[s]), 32'(exp));
        rr[s] = 1'b1;
        @(posedge clk); #1;
        rr[s] = 1'b0;
        check($sformatf("valid_after_take[%0d,%b]", s, c), 32'(rv[s]), 32'd0);
        check($sformatf("ready_after_take[%0d,%b]", s, c), 32'(crdy[s]), 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int s = 0; s < 3; s++) begin
            cv[s] = 1'b0;
            ch[s] = 4'b0000;
            rr[s] = 1'b0;
        end

        vecs[0]  = '{0, 4'b0000, 2'b01, 5};
        vecs[1]  = '{0, 4'b1111, 2'b00, 5};
        vecs[2]  = '{0, 4'b0001, 2'b01, 5};
        vecs[3]  = '{0, 4'b1000, 2'b00, 5};
        vecs[4]  = '{0, 4'b0010, 2'b01, 5};
        vecs[5]  = '{0, 4'b0100, 2'b00, 5};
        vecs[6]  = '{0, 4'b1010, 2'b00, 5};
        vecs[7]  = '{1, 4'b0000, 2'b01, 15};
        vecs[8]  = '{2, 4'b0000, 2'b01, 5};
        vecs[9]  = '{2, 4'b1111, 2'b00, 5};
        vecs[10] = '{2, 4'b1000, 2'b10, 5};

        // Reset values while held low.
        rst = 1'b0;
        #22;
        for (int s = 0; s < 3; s++) begin
            check($sformatf("rst_chal_ready[%0d]", s), 32'(crdy[s]), 32'd1);
            check($sformatf("rst_resp_valid[%0d]", s), 32'(rv[s]), 32'd0);
            check($sformatf("rst_response[%0d]", s), 32'(rsp[s]), 32'd0);
            check($sformatf("rst_busy[%0d]", s), 32'(bsy[s]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("idle_after_release_ready", 32'(crdy[0]), 32'd1);
        check("idle_after_release_busy", 32'(bsy[0]), 32'd0);

        for (int v = 0; v < 11; v++) begin
            run(vecs[v].sel, vecs[v].chal, vecs[v].exp, vecs[v].lat);
        end

        // Backpressure: hold DONE for 20 cycles while a new challenge is offered.
        @(posedge clk); #1;
        cv[0] = 1'b1;
        ch[0] = 4'b0000;
        @(posedge clk); #1;
        cv[0] = 1'b0;
        for (int e = 0; e < 5; e++) begin
            @(posedge clk); #1;
        end
        check("bp_enter_done", 32'(rv[0]), 32'd1);
        cv[0] = 1'b1;
        ch[0] = 4'b1000;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk); #1;
            check($sformatf("bp_valid[%0d]", e), 32'(rv[0]), 32'd1);
            check($sformatf("bp_response[%0d]", e), 32'(rsp[0]), 32'd1);
            check($sformatf("bp_chal_ready[%0d]", e), 32'(crdy[0]), 32'd0);
        end
        cv[0] = 1'b0;
        rr[0] = 1'b1;
        @(posedge clk); #1;
        rr[0] = 1'b0;
        check("bp_release_valid", 32'(rv[0]), 32'd0);
        check("bp_release_ready", 32'(crdy[0]), 32'd1);
        check("bp_release_busy", 32'(bsy[0]), 32'd0);

        // Ignored resp_ready while idle must not disturb the next evaluation.
        rr[0] = 1'b1;
        @(posedge clk); #1;
        rr[0] = 1'b0;
        run(0, 4'b0001, 2'b01, 5);

        // Reset mid-STAGE on the two-chain engine (its last response was 2'b10).
        @(posedge clk); #1;
        cv[2] = 1'b1;
        ch[2] = 4'b0000;
        @(posedge clk); #1;
        cv[2] = 1'b0;
        @(posedge clk); #1;
        check("midrst_busy_before", 32'(bsy[2]), 32'd1);
        rst = 1'b0;
        #1;
        check("midrst_chal_ready", 32'(crdy[2]), 32'd1);
        check("midrst_resp_valid", 32'(rv[2]), 32'd0);
        check("midrst_response", 32'(rsp[2]), 32'd0);
        check("midrst_busy", 32'(bsy[2]), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run(2, 4'b0000, 2'b01, 5);
        run(1, 4'b0000, 2'b01, 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
